// File: rtl/image_pkg.sv
// Shared FSM encoding and width helper for the image_write stream-to-memory packer.
package image_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/image_pack.sv
// Lane packer: collects pixels into a word, zero-filling lanes above the current one on pad.
module image_pack #(
   parameter int unsigned DEPTH_NB  = 2,
   parameter int unsigned IMG_WIDTH = 16,
   parameter int unsigned LW        = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          pix_val,
   input  logic [IMG_WIDTH-1:0]          pix_data,
   input  logic [LW-1:0]                 lane,
   input  logic                          pad,
   output logic [DEPTH_NB*IMG_WIDTH-1:0] word
);

   logic [DEPTH_NB-1:0][IMG_WIDTH-1:0] lanes_q, lanes_d;

   // word includes the pixel arriving this cycle, so the closing lane is written directly
   always_comb begin
      lanes_d = lanes_q;
      if (pix_val) lanes_d[lane] = pix_data;
      if (pad) begin
         for (int k = 0; k < int'(DEPTH_NB); k++) begin
            if (k > int'(lane)) lanes_d[k] = '0;
         end
      end
   end

   assign word = lanes_d;

   always_ff @(posedge clk) begin
      if (rst || clr) lanes_q <= '0;
      else            lanes_q <= lanes_d;
   end

endmodule

// File: rtl/image_write.sv
// Packs a pixel stream into DEPTH_NB-lane words written to consecutive image_mem addresses.
// Define IMAGE_WRITE_PAD_EN to add str_last, which closes and zero-pads the current word early.
module image_write
   import image_pkg::*;
#(
   parameter int unsigned DEPTH_NB   = 2,
   parameter int unsigned IMG_WIDTH  = 16,
   parameter int unsigned MEM_AWIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_val,
   input  logic [MEM_AWIDTH-1:0]         cfg_addr,
   input  logic [MEM_AWIDTH-1:0]         cfg_len,
   output logic                          cfg_rdy,
   input  logic                          str_val,
   input  logic [IMG_WIDTH-1:0]          str_data,
`ifdef IMAGE_WRITE_PAD_EN
   input  logic                          str_last,
`endif
   output logic                          str_rdy,
   output logic                          wr_val,
   output logic [MEM_AWIDTH-1:0]         wr_addr,
   output logic [IMG_WIDTH*DEPTH_NB-1:0] wr_data,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned LW = (clog2(DEPTH_NB) > 0) ? clog2(DEPTH_NB) : 1;
   localparam int unsigned DW = IMG_WIDTH * DEPTH_NB;

   state_e                state_q, state_d;
   logic [LW-1:0]         lane_q;
   logic [MEM_AWIDTH-1:0] addr_q;
   logic [MEM_AWIDTH-1:0] rem_q;
   logic                  wr_val_q;
   logic [MEM_AWIDTH-1:0] wr_addr_q;
   logic [DW-1:0]         wr_data_q;
   logic [DW-1:0]         pack_word;

   logic cfg_go, accept, last_lane, pad, close, last_word;

   assign cfg_go    = cfg_val && (state_q == StIdle);
   assign accept    = str_val && (state_q == StLoad);
   assign last_lane = (lane_q == LW'(DEPTH_NB - 1));
`ifdef IMAGE_WRITE_PAD_EN
   assign pad       = accept && str_last;
`else
   assign pad       = 1'b0;
`endif
   assign close     = accept && (last_lane || pad);
   // rem_q counts words not yet closed; the one closing now is the last if only it remains
   assign last_word = close && ((rem_q == MEM_AWIDTH'(1)) || pad);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cfg_val) state_d = (cfg_len == '0) ? StDone : StLoad;
         end
         StLoad: begin
            if (last_word) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign cfg_rdy = (state_q == StIdle);
   assign str_rdy = (state_q == StLoad);
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign wr_val  = wr_val_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         lane_q    <= '0;
         addr_q    <= '0;
         rem_q     <= '0;
         wr_val_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_val_q <= close;
         if (cfg_go) begin
            addr_q <= cfg_addr;
            rem_q  <= cfg_len;
            lane_q <= '0;
         end
         if (accept) lane_q <= close ? '0 : lane_q + 1'b1;
         if (close) begin
            wr_addr_q <= addr_q;
            wr_data_q <= pack_word;
            addr_q    <= addr_q + 1'b1;
            rem_q     <= rem_q - 1'b1;
         end
      end
   end

   image_pack #(
      .DEPTH_NB  (DEPTH_NB),
      .IMG_WIDTH (IMG_WIDTH),
      .LW        (LW)
   ) u_pack (
      .clk      (clk),
      .rst      (rst),
      .clr      (cfg_go || close),
      .pix_val  (accept),
      .pix_data (str_data),
      .lane     (lane_q),
      .pad      (pad),
      .word     (pack_word)
   );

endmodule

// File: tb/tb_image_write.sv
// Self-checking bench for image_write (DEPTH_NB=2, IMG_WIDTH=16) against a transfer-level model.
module tb_image_write;

   logic        clk;
   logic        rst;
   logic        cfg_val;
   logic [15:0] cfg_addr;
   logic [15:0] cfg_len;
   logic        cfg_rdy;
   logic        str_val;
   logic [15:0] str_data;
`ifdef IMAGE_WRITE_PAD_EN
   logic        str_last;
`endif
   logic        str_rdy;
   logic        wr_val;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   // Last word the model expects on the write port; held while wr_val is low
   logic [15:0] last_addr;
   logic [31:0] last_data;

   image_write #(
      .DEPTH_NB   (2),
      .IMG_WIDTH  (16),
      .MEM_AWIDTH (16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_val  (cfg_val),
      .cfg_addr (cfg_addr),
      .cfg_len  (cfg_len),
      .cfg_rdy  (cfg_rdy),
      .str_val  (str_val),
      .str_data (str_data),
`ifdef IMAGE_WRITE_PAD_EN
      .str_last (str_last),
`endif
      .str_rdy  (str_rdy),
      .wr_val   (wr_val),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Called at a negedge; leaves the bench at the negedge one cycle after rst is released.
   task automatic do_reset();
      rst     = 1'b1;
      cfg_val = 1'b0;
      str_val = 1'b0;
      @(negedge clk);
      @(negedge clk);
      last_addr = '0;
      last_data = '0;
      check("rst_cfg_rdy", cfg_rdy, 1);
      check("rst_str_rdy", str_rdy, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_val", wr_val, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_wr_val", wr_val, 0);
      check("post_rst_cfg_rdy", cfg_rdy, 1);
   endtask

   // One transfer. vmode: 0 str_val always high, 1 alternating, 2 random.
   // last_at: pixel index carrying str_last (-1 none); abort_at: return once that many
   // pixels are accepted (-1 none). Starts and ends at a negedge.
   task automatic run_xfer(input logic [15:0] base, input logic [15:0] len, input int vmode,
                           input bit seq, input int last_at, input int abort_at);
      logic [15:0] pix[$];
      logic [15:0] hi;
      int          npix, nw, idx, nwr, cyc;
      bit          pending, exp_rdy, exp_done, acc, fin;
      npix = (last_at >= 0) ? last_at + 1 : 2 * int'(len);
      nw   = (npix + 1) / 2;
      for (int i = 0; i < npix; i++) pix.push_back(seq ? 16'(i) : 16'($urandom));

      check("cfg_rdy_idle", cfg_rdy, 1);
      check("busy_idle", busy, 0);
      cfg_val  = 1'b1;
      cfg_addr = base;
      cfg_len  = len;
      @(posedge clk);
      #1;
      cfg_val = 1'b0;
      @(negedge clk);

      idx = 0; nwr = 0; pending = 0; fin = 0;
      for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
         check("wr_val", wr_val, pending);
         if (pending) begin
            hi = (2 * nwr + 1 < npix) ? pix[2*nwr+1] : 16'h0;
            last_addr = base + 16'(nwr);
            last_data = {hi, pix[2*nwr]};
            nwr++;
         end
         check("wr_addr", wr_addr, last_addr);
         check("wr_data", wr_data, last_data);
         exp_done = (len == 0) ? (cyc == 0) : (pending && nwr == nw);
         exp_rdy  = (idx < npix);
         check("done", done, exp_done);
         check("busy", busy, 1);
         check("cfg_rdy_busy", cfg_rdy, 0);
         check("str_rdy", str_rdy, exp_rdy);
         if (exp_done) begin
            fin     = 1;
            cfg_val = 1'b0;
            str_val = 1'($urandom);
         end else if (idx == abort_at) begin
            str_val = 1'b0;
            return;
         end else begin
            unique case (vmode)
               0:       str_val = 1'b1;
               1:       str_val = (cyc % 2 == 0);
               default: str_val = ($urandom_range(0, 99) < 60);
            endcase
            str_data = (idx < npix) ? pix[idx] : 16'($urandom);
`ifdef IMAGE_WRITE_PAD_EN
            str_last = (idx == last_at);
`endif
            // Commands must be ignored while a transfer is in flight
            cfg_val  = 1'($urandom);
            cfg_addr = 16'($urandom);
            cfg_len  = 16'($urandom);
            acc      = str_val && exp_rdy;
            pending  = acc && ((idx % 2 == 1) || (idx == npix - 1));
            if (acc) idx++;
         end
         @(negedge clk);
      end
      check("done_seen", fin, 1);
      str_val = 1'b0;
`ifdef IMAGE_WRITE_PAD_EN
      str_last = 1'b0;
`endif
      check("writes", nwr, nw);
      check("end_wr_val", wr_val, 0);
      check("end_done", done, 0);
      check("end_busy", busy, 0);
      check("end_cfg_rdy", cfg_rdy, 1);
      check("end_str_rdy", str_rdy, 0);
   endtask

   initial begin
      rst      = 1'b1;
      cfg_val  = 1'b0;
      cfg_addr = '0;
      cfg_len  = '0;
      str_val  = 1'b0;
      str_data = '0;
`ifdef IMAGE_WRITE_PAD_EN
      str_last = 1'b0;
`endif
      @(negedge clk);
      do_reset();

      run_xfer(16'h0000, 16'd11, 0, 1, -1, -1);
      run_xfer(16'h0000, 16'd11, 1, 1, -1, -1);
      run_xfer(16'hFFFF, 16'd3, 2, 0, -1, -1);
      run_xfer(16'($urandom), 16'd0, 0, 0, -1, -1);

      run_xfer(16'h0040, 16'd4, 0, 1, -1, 5);
      do_reset();
      run_xfer(16'h0100, 16'd2, 0, 0, -1, -1);

`ifdef IMAGE_WRITE_PAD_EN
      run_xfer(16'h0020, 16'd4, 0, 1, 4, -1);
      run_xfer(16'h0030, 16'd2, 0, 0, 3, -1);
      for (int t = 0; t < 4; t++) begin
         int l;
         l = $urandom_range(1, 5);
         run_xfer(16'($urandom), 16'(l), 2, 0, $urandom_range(0, 2 * l - 1), -1);
      end
`endif

      for (int t = 0; t < 10; t++) begin
         run_xfer(16'($urandom), 16'($urandom_range(0, 6)), $urandom_range(0, 2), 0, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
